result_fifo_drain_adapter: RTL and testbench
============================================

# result_fifo_drain_adapter

Bridges a show-ahead FIFO-read return port (rden/empty/data, as produced by exported method results such as `TimesFive`) to a registered valid/ready stream for downstream consumers. It sits directly downstream of the method's result FIFO. It pops results at up to one per cycle through a two-entry buffer, tags each result with a wrapping sequence number, and counts completed transfers. `rden_out` depends only on `empty_in` and registered state, so there is no combinational path from `ready_in` to `rden_out`.

## Interface
- `WIDTH`, 32: result data width.
- `SEQ_WIDTH`, 8: sequence tag width; the tag wraps modulo 2^SEQ_WIDTH.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `empty_in` in 1: upstream FIFO empty; when low, `data_in` holds the head entry.
- `data_in` in WIDTH: upstream head entry (show-ahead).
- `rden_out` out 1: pop request; the head is consumed in any cycle where `rden_out && !empty_in`.
- `stall_in` in 1: debug back-pressure; forces `rden_out` low while high.
- `valid_out` out 1: `data_out`/`seq_out` are valid.
- `data_out` out WIDTH: oldest buffered result.
- `seq_out` out SEQ_WIDTH: tag of `data_out`.
- `ready_in` in 1: downstream accepts; a transfer occurs when `valid_out && ready_in`.
- `count_out` out 32: number of completed downstream transfers, wrapping at 2^32.

## Operation
- The state is buffer occupancy: EMPTY(0), ONE(1), TWO(2).
- Pop rule: `rden_out = !rst_active && !stall_in && !empty_in && (occ != TWO)`.
- Push: a popped entry is written to the buffer tail with tag `seq_q`; `seq_q` then increments and wraps from 2^SEQ_WIDTH-1 to 0.
- Output: `valid_out = (occ != EMPTY)`. `data_out` and `seq_out` always present the head entry, from registers.
- Transitions:
  - EMPTY: a pop moves to ONE.
  - ONE: a pop with a transfer stays in ONE, and the head is replaced by the popped entry. A pop alone moves to TWO. A transfer alone moves to EMPTY.
  - TWO: no pop is possible. A transfer moves to ONE, and the second entry becomes the head.
- Ordering is strict FIFO, with no loss and no duplication.
- `count_out` increments by one on each transfer.
- Reset, asserted at any time:
  - Outputs are cleared asynchronously: `valid_out`=0, `occ`=EMPTY, `seq_out`=0, `data_out`=0, `count_out`=0, `rden_out`=0.
  - Buffered entries are discarded. No pop occurs while `rst` is low.
  - Operation resumes on the first rising edge after `rst` deasserts.

## Timing
- Latency: an entry popped at edge N is visible on `valid_out`/`data_out` after edge N (the same cycle the pop completes registers it). The minimum pop-to-transfer latency is 1 cycle.
- Throughput: one entry per cycle in steady state with `ready_in` high; occupancy holds at ONE.
- Back-pressure: `ready_in` low for k≥1 cycles fills the buffer to TWO within one pop. `rden_out` deasserts the cycle after occupancy reaches TWO and reasserts in the cycle after the first transfer.
- A simultaneous pop and transfer in state ONE is legal and must not stall.
- `valid_out` must not deassert without a transfer. `data_out` and `seq_out` stay stable while `valid_out && !ready_in`.
- `stall_in` takes effect combinationally in the same cycle; buffered data still drains.

## Structure
- Shared package `result_drain_pkg`:
  - occupancy enum `occ_t` {OCC_EMPTY, OCC_ONE, OCC_TWO};
  - localparam `COUNT_WIDTH` = 32.
- One sub-module, `two_entry_tagged_buffer`: registered head/tail storage of {data, seq} plus occupancy, with push/pop ports.
- The top level holds the pop rule, the sequence counter and the transfer counter.

## Test plan
- Single result: upstream holds 7 with `ready_in` high. Require one `rden_out` pulse, then `valid_out` with `data_out`=7 and `seq_out`=0. `count_out` becomes 1.
- Streaming: upstream results i*5 for i=0..9, `ready_in` high. Require `rden_out` high for 10 consecutive cycles and 10 transfers in 10 consecutive cycles. Data must be 0,5,…,45 and `seq_out` 0..9; final `count_out` is 10.
- Back-pressure: stream 0..9 with `ready_in` low for cycles 3–7. Require occupancy TWO, `rden_out` low during the hold, and `data_out` stable. All 10 values must arrive in order.
- Wrap: 260 results with `SEQ_WIDTH`=8. Require `seq_out` to go 255 then 0 on results 255→256; `count_out` is 260.
- Stall: `stall_in` high for 4 cycles mid-stream. Require no pops during the stall, the buffer to drain to EMPTY, and no data loss after release.
- Reset mid-operation: assert `rst` low with occupancy TWO. Require all outputs to be 0 immediately (asynchronously). After release, the next result carries `seq_out`=0 and `count_out` restarts from 1.

Source files
------------

// File: rtl/result_drain_pkg.sv
// Shared types for the result FIFO drain adapter.
// Occupancy encoding and counter width.
package result_drain_pkg;
  localparam int COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_t;
endpackage

// File: rtl/result_fifo_drain_adapter_buffer.sv
// Two-entry registered buffer of {data, seq}.
// Head is always presented; tail is only used in OCC_TWO.
module two_entry_tagged_buffer
  import result_drain_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEQ_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic [SEQ_WIDTH-1:0] push_seq,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic [SEQ_WIDTH-1:0] head_seq,
  output occ_t                 occ
);
  localparam int EW = WIDTH + SEQ_WIDTH;

  occ_t          occ_q, occ_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic [EW-1:0] entry;

  assign entry = {push_data, push_seq};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = entry;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = entry;
        end else if (push) begin
          tail_d = entry;
          occ_d  = OCC_TWO;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign head_data = head_q[EW-1:SEQ_WIDTH];
  assign head_seq  = head_q[SEQ_WIDTH-1:0];
  assign occ       = occ_q;
endmodule

// File: rtl/result_fifo_drain_adapter.sv
// Drains a show-ahead result FIFO into a tagged valid/ready stream.
// Pop depends only on empty/stall and registered occupancy.
module result_fifo_drain_adapter
  import result_drain_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEQ_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   empty_in,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   rden_out,
  input  logic                   stall_in,
  output logic                   valid_out,
  output logic [WIDTH-1:0]       data_out,
  output logic [SEQ_WIDTH-1:0]   seq_out,
  input  logic                   ready_in,
  output logic [COUNT_WIDTH-1:0] count_out
);
  occ_t                   occ;
  logic                   xfer;
  logic [SEQ_WIDTH-1:0]   seq_q;
  logic [COUNT_WIDTH-1:0] count_q;

  assign rden_out  = rst && !stall_in && !empty_in
                   && (occ != OCC_TWO);
  assign valid_out = (occ != OCC_EMPTY);
  assign xfer      = valid_out && ready_in;
  assign count_out = count_q;

  two_entry_tagged_buffer #(
    .WIDTH     (WIDTH),
    .SEQ_WIDTH (SEQ_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rden_out),
    .push_data (data_in),
    .push_seq  (seq_q),
    .pop       (xfer),
    .head_data (data_out),
    .head_seq  (seq_out),
    .occ       (occ)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q   <= '0;
      count_q <= '0;
    end else begin
      if (rden_out) seq_q <= seq_q + 1'b1;
      if (xfer) count_q <= count_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_result_fifo_drain_adapter.sv
// Scoreboard bench for result_fifo_drain_adapter.
// Upstream FIFO and buffer occupancy are modelled by queues.
module tb_result_fifo_drain_adapter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        empty_in = 1'b1;
  logic [31:0] data_in = '0;
  logic        rden_out;
  logic        stall_in = 1'b0;
  logic        valid_out;
  logic [31:0] data_out;
  logic [7:0]  seq_out;
  logic        ready_in = 1'b0;
  logic [31:0] count_out;

  result_fifo_drain_adapter #(.WIDTH(32), .SEQ_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty_in  (empty_in),
    .data_in   (data_in),
    .rden_out  (rden_out),
    .stall_in  (stall_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .seq_out   (seq_out),
    .ready_in  (ready_in),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] src[$];
  logic [39:0] sb[$];
  logic [7:0]  seq_m = '0;
  logic [31:0] cnt_m = '0;
  int          pops = 0;
  int          xfers = 0;
  bit          in_wrap = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input bit rdy, input bit stl);
    logic [39:0] e;
    bit pop_m, xfer_m;
    ready_in = rdy;
    stall_in = stl;
    empty_in = (src.size() == 0);
    data_in  = empty_in ? '0 : src[0];
    @(negedge clk);
    pop_m  = !stl && src.size() != 0 && sb.size() < 2;
    xfer_m = rdy && sb.size() != 0;
    check("valid", valid_out, sb.size() != 0);
    check("rden", rden_out, pop_m);
    if (xfer_m) begin
      e = sb.pop_front();
      check("data", data_out, e[39:8]);
      check("seq", seq_out, e[7:0]);
      if (in_wrap && xfers == 255) check("wrap_seq255", seq_out, 255);
      if (in_wrap && xfers == 256) check("wrap_seq0", seq_out, 0);
      cnt_m++;
      xfers++;
    end
    if (pop_m) begin
      sb.push_back({src.pop_front(), seq_m});
      seq_m++;
      pops++;
    end
    @(posedge clk);
    #1;
    check("count", count_out, cnt_m);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((src.size() != 0 || sb.size() != 0) && n < max) begin
      tick(1, 0);
      n++;
    end
    check("drain_timeout", src.size() + sb.size(), 0);
  endtask

  task automatic release_rst();
    empty_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #2;
    rst = 1'b0;
    sb.delete();
    seq_m = '0;
    cnt_m = '0;
    release_rst();
  endtask

  initial begin
    empty_in = 1'b0;
    data_in  = 32'h55;
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_rden", rden_out, 0);
    check("rst_data", data_out, 0);
    check("rst_seq", seq_out, 0);
    check("rst_count", count_out, 0);
    release_rst();

    // single result
    src.push_back(32'd7);
    pops = 0;
    drain(20);
    check("single_pops", pops, 1);
    check("single_count", count_out, 1);

    // streaming
    for (int i = 0; i < 10; i++) src.push_back(i * 5);
    pops = 0;
    xfers = 0;
    repeat (10) tick(1, 0);
    check("stream_pops", pops, 10);
    tick(1, 0);
    check("stream_xfers", xfers, 10);
    check("stream_count", count_out, 11);

    // back-pressure, ready low in cycles 3..7
    for (int i = 0; i < 10; i++) src.push_back(32'h100 + i);
    for (int c = 1; c <= 12; c++) begin
      tick(!(c >= 3 && c <= 7), 0);
      if (c == 7) begin
        check("bp_rden_low", rden_out, 0);
        check("bp_valid", valid_out, 1);
        check("bp_head", data_out, sb[0][39:8]);
      end
    end
    drain(40);

    // sequence wrap after a clean reset
    pulse_rst();
    for (int i = 0; i < 260; i++) src.push_back($urandom);
    xfers = 0;
    in_wrap = 1;
    drain(600);
    in_wrap = 0;
    check("wrap_count", count_out, 260);

    // stall mid-stream
    for (int i = 0; i < 10; i++) src.push_back(32'h200 + i);
    repeat (3) tick(1, 0);
    repeat (4) tick(1, 1);
    check("stall_drained", valid_out, 0);
    drain(40);

    // reset with two entries buffered
    for (int i = 0; i < 5; i++) src.push_back(32'h300 + i);
    repeat (3) tick(0, 0);
    check("mid_valid", valid_out, 1);
    check("mid_rden", rden_out, 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", valid_out, 0);
    check("arst_data", data_out, 0);
    check("arst_seq", seq_out, 0);
    check("arst_count", count_out, 0);
    check("arst_rden", rden_out, 0);
    sb.delete();
    seq_m = '0;
    cnt_m = '0;
    release_rst();
    tick(1, 0);
    tick(1, 0);
    check("post_rst_count", count_out, 1);
    drain(20);
    check("post_rst_total", count_out, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
